// File: rtl/proc_pkg.sv
// proc_pkg: shared word type, opcodes and R-type function codes for the proc_hier core
package proc_pkg;

    typedef logic [15:0] word_t;

    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_RTYPE = 5'b11011;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_J     = 5'b00100;

    typedef enum logic [1:0] {
        FN_ADD  = 2'b00,
        FN_SUB  = 2'b01,
        FN_XOR  = 2'b10,
        FN_ANDN = 2'b11
    } func_e;

endpackage

// File: rtl/proc_regfile.sv
// proc_regfile: 8x16 register file, two combinational read ports, one synchronous write port
module proc_regfile
    import proc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       we,
    input  logic [2:0] waddr,
    input  word_t      wdata,
    input  logic [2:0] raddr_a,
    input  logic [2:0] raddr_b,
    output word_t      rdata_a,
    output word_t      rdata_b
);

    word_t regs_q [8];
    word_t regs_d [8];

    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];

    // Apply the single write; reads in the same cycle still see the old value
    always_comb begin
        regs_d = regs_q;
        if (we)
            regs_d[waddr] = wdata;
    end

    // Register storage, cleared by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++)
                regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/proc_hier.sv
// proc_hier: 16-bit single-cycle core; define PROC_TRACE_EN to drive the pc/inst/data trace outputs
module proc_hier
    import proc_pkg::*;
#(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_en,
    input  logic        load_sel,
    input  logic [15:0] load_addr,
    input  logic [15:0] load_data,
    output logic [31:0] cycle_count,
    output logic [15:0] pc,
    output logic [15:0] inst,
    output logic        reg_write,
    output logic [2:0]  write_reg,
    output logic [15:0] write_data,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic [15:0] mem_data_out,
    output logic        halt
);

    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    word_t          imem [IMEM_WORDS];
    word_t          dmem [DMEM_WORDS];
    word_t          pc_q, pc_d, pc_seq, pc_nx;
    logic           halted_q, halted_d;
    logic [31:0]    cycle_q, cycle_d;
    word_t          inst_w, rs_val, rt_val, imm5, imm8, disp11, addr, ld_val, alu_r, wval;
    logic [4:0]     op;
    logic [2:0]     rs, rt, rd, wsel;
    func_e          fn;
    logic           raw_we, raw_rd, raw_wr, raw_halt, active, rf_we, st_en, pre_i, pre_d;
    logic [IAW-1:0] imem_idx, iload_idx;
    logic [DAW-1:0] dmem_idx, dload_idx;
    logic           unused_bits;

    assign imem_idx  = IAW'({17'd0, pc_q[15:1]} % IMEM_WORDS);
    assign iload_idx = IAW'({17'd0, load_addr[15:1]} % IMEM_WORDS);
    assign dmem_idx  = DAW'({17'd0, addr[15:1]} % DMEM_WORDS);
    assign dload_idx = DAW'({17'd0, load_addr[15:1]} % DMEM_WORDS);

    assign inst_w = imem[imem_idx];
    assign op     = inst_w[15:11];
    assign rs     = inst_w[10:8];
    assign rt     = inst_w[7:5];
    assign rd     = inst_w[4:2];
    assign fn     = func_e'(inst_w[1:0]);
    assign imm5   = {{11{inst_w[4]}}, inst_w[4:0]};
    assign imm8   = {{8{inst_w[7]}}, inst_w[7:0]};
    assign disp11 = {{5{inst_w[10]}}, inst_w[10:0]};
    assign pc_seq = pc_q + 16'd2;
    assign addr   = rs_val + imm5;
    assign ld_val = dmem[dmem_idx];

    // Nothing commits under reset or once halted
    assign active    = !rst && !halted_q;
    assign rf_we     = active && raw_we;
    assign st_en     = active && raw_wr;
    assign pre_i     = rst && load_en && !load_sel;
    assign pre_d     = rst && load_en && load_sel;
    assign reg_write = rf_we;
    assign mem_read  = active && raw_rd;
    assign mem_write = st_en;
    assign halt      = !rst && (halted_q || raw_halt);

    assign cycle_count = cycle_q;
    assign unused_bits = ^{load_addr[0], addr[0]};

    proc_regfile u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (wsel),
        .wdata   (wval),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (rs_val),
        .rdata_b (rt_val)
    );

    // R-type result selected by the function field
    always_comb begin
        alu_r = fn == FN_ADD ? rs_val + rt_val :
                fn == FN_SUB ? rt_val - rs_val :
                fn == FN_XOR ? rs_val ^ rt_val : rs_val & ~rt_val;
    end

    // Decode the current instruction into raw write/read/halt intents and the next PC
    always_comb begin
        raw_we   = 1'b0;
        raw_rd   = 1'b0;
        raw_wr   = 1'b0;
        raw_halt = 1'b0;
        wsel     = rt;
        wval     = addr;
        pc_nx    = pc_seq;
        case (op)
            OP_HALT:  begin raw_halt = 1'b1; pc_nx = pc_q; end
            OP_NOP:   ;
            OP_ADDI:  raw_we = 1'b1;
            OP_SUBI:  begin raw_we = 1'b1; wval = imm5 - rs_val; end
            OP_ST:    raw_wr = 1'b1;
            OP_LD:    begin raw_we = 1'b1; raw_rd = 1'b1; wval = ld_val; end
            OP_LBI:   begin raw_we = 1'b1; wsel = rs; wval = imm8; end
            OP_RTYPE: begin raw_we = 1'b1; wsel = rd; wval = alu_r; end
            OP_BEQZ:  pc_nx = rs_val == '0 ? pc_seq + imm8 : pc_seq;
            OP_J:     pc_nx = pc_seq + disp11;
            default:  ;
        endcase
    end

    // Next architectural state; the cycle counter runs even while halted
    always_comb begin
        pc_d     = active ? pc_nx : pc_q;
        halted_d = halted_q || (active && raw_halt);
        cycle_d  = cycle_q + 32'd1;
    end

    // Core state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= '0;
            halted_q <= 1'b0;
            cycle_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            cycle_q  <= cycle_d;
        end
    end

    // Memories are not reset: preload while in reset, stores while running
    always_ff @(posedge clk) begin
        if (pre_i)
            imem[iload_idx] <= load_data;
        if (pre_d)
            dmem[dload_idx] <= load_data;
        else if (st_en)
            dmem[dmem_idx] <= rt_val;
    end

`ifdef PROC_TRACE_EN
    assign pc           = pc_q;
    assign inst         = inst_w;
    assign write_reg    = wsel;
    assign write_data   = wval;
    assign mem_addr     = addr;
    assign mem_data_in  = rt_val;
    assign mem_data_out = ld_val;
`else
    assign pc           = '0;
    assign inst         = '0;
    assign write_reg    = '0;
    assign write_data   = '0;
    assign mem_addr     = '0;
    assign mem_data_in  = '0;
    assign mem_data_out = '0;
`endif

endmodule

// File: tb/tb_proc_hier.sv
// tb_proc_hier: directed and random programs checked against an instruction-level model
module tb_proc_hier;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_en = 1'b0;
    logic        load_sel = 1'b0;
    logic [15:0] load_addr = '0;
    logic [15:0] load_data = '0;
    logic [31:0] cycle_count;
    logic [15:0] pc, inst, write_data, mem_addr, mem_data_in, mem_data_out;
    logic [2:0]  write_reg;
    logic        reg_write, mem_read, mem_write, halt;

    int tests = 0;
    int fails = 0;

    logic [15:0] m_imem [256];
    logic [15:0] m_dmem [256];
    logic [15:0] m_r [8];
    logic [15:0] m_pc;
    logic        m_halted;
    logic [31:0] m_cycle;
    logic [15:0] prog_q [$];

    always #5 clk = ~clk;

    proc_hier dut (
        .clk          (clk),
        .rst          (rst),
        .load_en      (load_en),
        .load_sel     (load_sel),
        .load_addr    (load_addr),
        .load_data    (load_data),
        .cycle_count  (cycle_count),
        .pc           (pc),
        .inst         (inst),
        .reg_write    (reg_write),
        .write_reg    (write_reg),
        .write_data   (write_data),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .halt         (halt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int sx(input logic [15:0] v, input int bits);
        int u;
        u = int'(v) & ((1 << bits) - 1);
        return u >= (1 << (bits - 1)) ? u - (1 << bits) : u;
    endfunction

    function automatic logic [15:0] e_i(input logic [4:0] op, input int rs, input int rt, input int imm);
        return {op, 3'(rs), 3'(rt), 5'(imm)};
    endfunction

    function automatic logic [15:0] e_b(input logic [4:0] op, input int rs, input int imm);
        return {op, 3'(rs), 8'(imm)};
    endfunction

    function automatic logic [15:0] e_r(input int rs, input int rt, input int rd, input int fn);
        return {5'b11011, 3'(rs), 3'(rt), 3'(rd), 2'(fn)};
    endfunction

    function automatic logic [15:0] e_j(input int d);
        return {5'b00100, 11'(d)};
    endfunction

    function automatic logic [15:0] rand_inst();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 10))
            0:       return {5'b00001, r[10:0]};
            1:       return {5'b01000, r[10:0]};
            2:       return {5'b01001, r[10:0]};
            3:       return {5'b10000, r[10:0]};
            4:       return {5'b10001, r[10:0]};
            5, 6:    return {5'b11000, r[10:0]};
            7:       return {5'b11011, r[10:0]};
            8:       return {5'b01100, r[10:0]};
            9:       return e_j(int'($urandom_range(0, 8)) * 2);
            default: return {5'b11110, r[10:0]};
        endcase
    endfunction

    task automatic preload(input logic sel, input int idx, input logic [15:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_sel  = sel;
        load_addr = 16'(idx * 2);
        load_data = d;
        @(posedge clk);
        #1 load_en = 1'b0;
    endtask

    task automatic load_prog(input bit with_data);
        logic [15:0] w;
        for (int i = 0; i < 256; i++) begin
            w = i < prog_q.size() ? prog_q[i] : 16'h0000;
            m_imem[i] = w;
            preload(1'b0, i, w);
        end
        if (with_data)
            for (int i = 0; i < 256; i++) begin
                w = 16'($urandom);
                m_dmem[i] = w;
                preload(1'b1, i, w);
            end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        for (int r = 0; r < 8; r++) m_r[r] = '0;
        m_pc = '0;
        m_halted = 1'b0;
        m_cycle = '0;
        chk("rst_reg_write", reg_write, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        chk("rst_halt", halt, 0);
        chk("rst_cycle", cycle_count, 0);
        chk("rst_pc", dut.pc_q, 0);
        for (int r = 0; r < 8; r++) chk($sformatf("rst_r%0d", r), dut.u_rf.regs_q[r], 0);
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run(input int n);
        logic [15:0] ins, a, b, wd, ma, nxt;
        logic [4:0]  op;
        logic [2:0]  wr;
        logic        ewe, erd, ewr, eh;
        int          di;
        for (int c = 0; c < n; c++) begin
            #1;
            ins = m_imem[m_pc[15:1] % 256];
            op  = ins[15:11];
            a   = m_r[ins[10:8]];
            b   = m_r[ins[7:5]];
            ma  = 16'(int'(a) + sx(ins, 5));
            di  = int'(ma[15:1]) % 256;
            ewe = 1'b0; erd = 1'b0; ewr = 1'b0; eh = m_halted;
            wr  = ins[7:5];
            wd  = ma;
            nxt = m_halted ? m_pc : m_pc + 16'd2;
            if (!m_halted)
                case (op)
                    5'b00000: begin eh = 1'b1; nxt = m_pc; end
                    5'b01000: ewe = 1'b1;
                    5'b01001: begin ewe = 1'b1; wd = 16'(sx(ins, 5) - int'(a)); end
                    5'b10000: ewr = 1'b1;
                    5'b10001: begin ewe = 1'b1; erd = 1'b1; wd = m_dmem[di]; end
                    5'b11000: begin ewe = 1'b1; wr = ins[10:8]; wd = 16'(sx(ins, 8)); end
                    5'b11011: begin
                        ewe = 1'b1;
                        wr  = ins[4:2];
                        wd  = ins[1:0] == 2'd0 ? a + b : ins[1:0] == 2'd1 ? b - a :
                              ins[1:0] == 2'd2 ? a ^ b : a & ~b;
                    end
                    5'b01100: if (a == 16'd0) nxt = 16'(int'(m_pc) + 2 + sx(ins, 8));
                    5'b00100: nxt = 16'(int'(m_pc) + 2 + sx(ins, 11));
                    default: ;
                endcase
            chk("reg_write", reg_write, ewe);
            chk("mem_read", mem_read, erd);
            chk("mem_write", mem_write, ewr);
            chk("halt", halt, eh);
            chk("cycle_count", cycle_count, m_cycle);
`ifdef PROC_TRACE_EN
            chk("pc", pc, m_pc);
            chk("inst", inst, ins);
            if (ewe) begin
                chk("write_reg", write_reg, wr);
                chk("write_data", write_data, wd);
            end
            if (erd || ewr) chk("mem_addr", mem_addr, ma);
            if (ewr) chk("mem_data_in", mem_data_in, b);
            if (erd) chk("mem_data_out", mem_data_out, m_dmem[di]);
`else
            chk("pc_tied", pc, 0);
            chk("inst_tied", inst, 0);
            chk("wdata_tied", write_data, 0);
            chk("maddr_tied", mem_addr, 0);
`endif
            if (ewe) m_r[wr] = wd;
            if (ewr) m_dmem[di] = b;
            m_halted = m_halted | eh;
            m_pc = nxt;
            m_cycle++;
            @(posedge clk);
            #1;
            for (int r = 0; r < 8; r++) chk($sformatf("r%0d", r), dut.u_rf.regs_q[r], m_r[r]);
            chk("pc_q", dut.pc_q, m_pc);
            if (ewr) chk("dmem", dut.dmem[di], m_dmem[di]);
            @(negedge clk);
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        do_reset();

        prog_q = '{e_b(5'b11000, 1, 5), 16'h0000};
        load_prog(1'b1);
        release_rst();
        run(5);
        chk("lbi_r1", dut.u_rf.regs_q[1], 16'h0005);
        chk("halt_pc", dut.pc_q, 16'h0002);
        chk("halt_sticky", halt, 1);
        chk("halt_cycles", cycle_count, 5);

        do_reset();
        prog_q = '{e_b(5'b11000, 1, 5), e_i(5'b01000, 1, 2, -1), e_i(5'b01001, 1, 3, 0),
                   e_i(5'b10000, 0, 1, 4), e_i(5'b10001, 0, 4, 4), 16'h0000};
        load_prog(1'b1);
        release_rst();
        run(8);
        chk("addi", dut.u_rf.regs_q[2], 16'h0004);
        chk("subi", dut.u_rf.regs_q[3], 16'hFFFB);
        chk("ld", dut.u_rf.regs_q[4], 16'h0005);
        chk("st", dut.dmem[2], 16'h0005);

        do_reset();
        prog_q = '{e_b(5'b11000, 1, 8'h78), e_r(1, 1, 1, 0), e_b(5'b11000, 2, 8'h0F)};
        for (int i = 0; i < 8; i++) prog_q.push_back(e_r(2, 2, 2, 0));
        prog_q.push_back(e_i(5'b01000, 2, 2, 15));
        for (int f = 0; f < 4; f++) prog_q.push_back(e_r(1, 2, 3 + f, f));
        prog_q.push_back(16'h0000);
        load_prog(1'b0);
        release_rst();
        run(20);
        chk("r_add", dut.u_rf.regs_q[3], 16'h0FFF);
        chk("r_sub", dut.u_rf.regs_q[4], 16'h0E1F);
        chk("r_xor", dut.u_rf.regs_q[5], 16'h0FFF);
        chk("r_andn", dut.u_rf.regs_q[6], 16'h00F0);

        do_reset();
        prog_q = {};
        for (int i = 0; i < 8; i++) prog_q.push_back(16'h0800);
        prog_q.push_back(e_b(5'b01100, 0, 4));
        prog_q.push_back(e_b(5'b11000, 7, 1));
        prog_q.push_back(e_b(5'b11000, 7, 1));
        prog_q.push_back(e_b(5'b11000, 1, 3));
        prog_q.push_back(e_b(5'b01100, 1, 4));
        prog_q.push_back(e_j(4));
        prog_q.push_back(16'h0800);
        prog_q.push_back(16'h0800);
        prog_q.push_back(e_j(-2));
        load_prog(1'b0);
        release_rst();
        run(9);
        chk("beqz_taken", dut.pc_q, 16'h0016);
        run(2);
        chk("beqz_not_taken", dut.pc_q, 16'h001A);
        run(5);
        chk("j_loop", dut.pc_q, 16'h0020);
        chk("skipped_r7", dut.u_rf.regs_q[7], 16'h0000);
        chk("loop_cycles", cycle_count, 16);
        chk("loop_no_halt", halt, 0);

        do_reset();
        release_rst();
        run(12);
        chk("dmem_retained", dut.dmem[2], 16'h0005);

        for (int p = 0; p < 6; p++) begin
            do_reset();
            prog_q = {};
            for (int i = 0; i < 40; i++) prog_q.push_back(rand_inst());
            load_prog(1'b1);
            release_rst();
            run(60);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/proc_hier.md
# proc_hier

Top-level hierarchy of a compact 16-bit single-cycle processor: program counter, 8×16 register file, word-organised instruction and data memories, and a reduced instruction subset. Every cycle one instruction is fetched, executed and committed on the rising clock edge. A per-cycle commit-trace port and a free-running cycle counter let the simulation bench log register writes, loads, stores and halt.

## Interface
- IMEM_WORDS, 256: instruction memory depth in 16-bit words.
- DMEM_WORDS, 256: data memory depth in 16-bit words.
- clk  in  1  single clock; everything is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- load_en  in  1  program/data preload strobe; honoured only while rst=1.
- load_sel  in  1  preload target: 0=instruction memory, 1=data memory.
- load_addr  in  16  preload byte address; bits [15:1] select the word.
- load_data  in  16  preload word.
- cycle_count  out  32  cycles elapsed since reset release.
- pc  out  16  address of the current instruction.
- inst  out  16  current instruction word.
- reg_write  out  1  current instruction writes a register.
- write_reg  out  3  destination register.
- write_data  out  16  value written.
- mem_read  out  1  current instruction is a load.
- mem_write  out  1  current instruction is a store.
- mem_addr  out  16  load/store byte address.
- mem_data_in  out  16  store data.
- mem_data_out  out  16  load data.
- halt  out  1  current instruction is HALT, or the core is halted.

## Operation
- Encoding: op=[15:11], Rs=[10:8], Rt=[7:5], Rd(R-type)=[4:2], imm5=[4:0], imm8=[7:0], disp11=[10:0]. All immediates are sign-extended.
- 00000 HALT: the core halts and the PC freezes.
- 00001 NOP.
- 01000 ADDI: Rt←Rs+imm5.
- 01001 SUBI: Rt←imm5−Rs.
- 10000 ST: Mem[Rs+imm5]←Rt.
- 10001 LD: Rt←Mem[Rs+imm5].
- 11000 LBI: Rs←imm8.
- 11011 R-type, func=[1:0]: 00 ADD Rd←Rs+Rt; 01 SUB Rd←Rt−Rs; 10 XOR; 11 ANDN Rd←Rs&~Rt.
- 01100 BEQZ: if Rs==0, PC←PC+2+imm8.
- 00100 J: PC←PC+2+disp11.
- Any other opcode executes as NOP.
- All arithmetic is 16-bit modulo 2^16 and sets no flags.
- Sequential PC is PC+2, wrapping at 0xFFFF→0x0000.
- Memory index is address[15:1] modulo depth. The low address bit is ignored.
- Register-file reads are combinational.
- A write to a register that is also read in the same cycle returns the old value.
- Trace outputs are combinational views of the current instruction. When the enable is 0, write_reg, write_data, mem_addr, mem_data_in and mem_data_out are don't-care.
- Halt is sticky: once HALT commits, pc, registers and memory are frozen and halt stays 1 until rst.

## Timing
- Reset (async) values: PC=0, all registers=0, cycle_count=0, halted=0.
- During reset, reg_write, mem_read, mem_write and halt are forced to 0.
- Memory contents are not reset.
- Preload writes occur at posedge clk when rst=1 and load_en=1.
- Latency: 1 cycle per instruction. Register and memory writes and the PC update commit at the posedge that ends the instruction's cycle.
- Data-memory reads are combinational; writes are synchronous.
- cycle_count increments at every posedge with rst=0, including while halted, and wraps at 2^32.
- Reset asserted mid-program aborts the instruction in flight; nothing is committed.

## Configuration
- PROC_TRACE_EN defined: all trace outputs behave as described above.
- PROC_TRACE_EN undefined: pc, inst, write_reg, write_data, mem_addr, mem_data_in and mem_data_out are tied to 0. reg_write, mem_read, mem_write and halt still operate.

## Structure
- Package proc_pkg holds:
  - opcode localparams (OP_HALT, OP_NOP, OP_ADDI, OP_SUBI, OP_ST, OP_LD, OP_LBI, OP_RTYPE, OP_BEQZ, OP_J);
  - the R-type func enum;
  - the 16-bit word typedef.
- Sub-module proc_regfile: 8×16 storage, two asynchronous read ports, one synchronous write port, asynchronous reset.
- Decode, ALU, PC logic and both memories live in proc_hier.

## Test plan
- Reset, then preload LBI r1,5; HALT and release reset → cycle 0: reg_write=1, write_reg=1, write_data=0x0005. Cycle 1: halt=1. pc then stays at 0x0002.
- ADDI r2←r1+(−1) with r1=5 → write_data=0x0004. SUBI r3←0−r1 → 0xFFFB.
- ST r1→[r0+4], then LD r4←[r0+4] → store cycle: mem_write=1, mem_addr=0x0004, mem_data_in=0x0005. Load cycle: mem_read=1, mem_data_out=0x0005, write_reg=4.
- R-type with r1=0x00F0, r2=0x0F0F: ADD=0x0FFF, SUB(Rt−Rs)=0x0E1F, XOR=0x0FFF, ANDN=0x00F0.
- BEQZ r0,+4 at PC 0x0010 → next pc=0x0016. BEQZ on nonzero Rs → 0x0012. J −2 at PC 0x0020 → 0x0020 (self-loop); cycle_count keeps incrementing.
- Assert rst for one cycle mid-program → pc=0, registers=0, cycle_count=0 immediately. Preloaded memory is retained.
